// File: rtl/oc_port_array.sv
// oc_port_array: interlocked open/close controller for NUM_PORTS chamber ports; define AUTO_CLOSE_EN for timed auto-close.
module oc_port_array #(
  parameter int NUM_PORTS     = 2,
  parameter int TRAVEL_CYCLES = 4,
  parameter int TRAVEL_W      = 8,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_PORTS-1:0] SwitchFlip,
  input  logic                 EVState,
  output logic [NUM_PORTS-1:0] OpenClose,
  output logic [NUM_PORTS-1:0] Moving,
  output logic                 Busy,
  output logic [NUM_PORTS-1:0] Denied
);
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
`ifdef AUTO_CLOSE_EN
  localparam int HOLD_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
`endif
  logic [NUM_PORTS-1:0] sw_q, req, closed, cand, grant;
  logic taken;
  if (NUM_PORTS < 1 || TRAVEL_CYCLES < 1 || HOLD_CYCLES < 1 || TRAVEL_CYCLES > 2**TRAVEL_W - 1) begin : g_bad_param
    $error("oc_port_array: parameter out of range");
  end
  assign req    = SwitchFlip & ~sw_q;
  assign cand   = req & closed;
  assign Busy   = ~&closed;
  // Lowest-index closed requester wins, and only if every other port is closed and the chamber is equalised
  always_comb begin
    grant = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = cand[i] & ~taken & EVState & (&(closed | (NUM_PORTS'(1) << i)));
      taken = taken | cand[i];
    end
  end
  // Switch history (ones after reset so a held switch needs a fresh press) and registered deny pulses
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sw_q   <= '1;
      Denied <= '0;
    end else begin
      sw_q   <= SwitchFlip;
      Denied <= cand & ~grant;
    end
  end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t state, state_nx;
    logic [TRAVEL_W-1:0] cnt, cnt_nx;
    logic close_req;
`ifdef AUTO_CLOSE_EN
    logic [HOLD_W-1:0] hold, hold_nx;
    assign close_req = req[p] || hold == '0;
    // Hold timer reloads whenever the port is not open and counts down while it is, stopping at zero
    always_comb hold_nx = state != OPEN ? HOLD_LOAD : hold == '0 ? hold : hold - 1'b1;
    // Hold timer register
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) hold <= '0;
      else hold <= hold_nx;
    end
`else
    assign close_req = req[p];
`endif
    assign closed[p]    = state == CLOSED;
    assign OpenClose[p] = state == OPEN;
    assign Moving[p]    = state == OPENING || state == CLOSING;
    // Port sequencing; losing EVState while opening or open forces a fresh full close travel
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
        CLOSED:
          if (grant[p]) begin
            state_nx = OPENING;
            cnt_nx   = TRAVEL_LOAD;
          end
        OPENING:
          if (!EVState) begin
            state_nx = CLOSING;
            cnt_nx   = TRAVEL_LOAD;
          end else if (cnt == '0) state_nx = OPEN;
          else cnt_nx = cnt - 1'b1;
        OPEN:
          if (!EVState || close_req) begin
            state_nx = CLOSING;
            cnt_nx   = TRAVEL_LOAD;
          end
        CLOSING:
          if (cnt == '0) state_nx = CLOSED;
          else cnt_nx = cnt - 1'b1;
        default: state_nx = CLOSED;
      endcase
    end
    // Port state and travel counter registers
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        state <= CLOSED;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end
  end
endmodule

// File: tb/tb_oc_port_array.sv
// tb_oc_port_array: directed test plan plus randomized run against a phase/timestamp model of the port array.
module tb_oc_port_array;
  localparam int NP = 2;
  localparam int T  = 4;
  localparam int H  = 3;
`ifdef AUTO_CLOSE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [NP-1:0] SwitchFlip = '1;
  logic          EVState = 1'b0;
  logic [NP-1:0] OpenClose, Moving, Denied;
  logic          Busy;
  int checks = 0;
  int errors = 0;

  oc_port_array #(.NUM_PORTS(NP), .TRAVEL_CYCLES(T), .TRAVEL_W(8), .HOLD_CYCLES(H)) dut (
    .Clock(Clock), .Reset(Reset), .SwitchFlip(SwitchFlip), .EVState(EVState),
    .OpenClose(OpenClose), .Moving(Moving), .Busy(Busy), .Denied(Denied)
  );

  always #5 Clock = ~Clock;

  // Model: phase per port (0 closed, 1 opening, 2 open, 3 closing) and the edge index on which it was entered
  int mst [NP] = '{default: 0};
  int ment [NP] = '{default: 0};
  int cyc = 0;
  logic [NP-1:0] mprev = '1;
  logic [NP-1:0] mden = '0;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NP; i++) mst[i] <= 0;
      mprev <= '1;
      mden  <= '0;
      cyc   <= 0;
    end else begin
      automatic logic [NP-1:0] r = SwitchFlip & ~mprev;
      automatic logic [NP-1:0] d = '0;
      automatic int first = -1;
      automatic int nbusy = 0;
      for (int i = 0; i < NP; i++) begin
        if (first < 0 && r[i] && mst[i] == 0) first = i;
        if (mst[i] != 0) nbusy++;
      end
      for (int i = 0; i < NP; i++) begin
        if (mst[i] == 0 && r[i]) begin
          if (EVState && nbusy == 0 && first == i) begin
            mst[i] <= 1; ment[i] <= cyc;
          end else d[i] = 1'b1;
        end else if (mst[i] == 1) begin
          if (!EVState) begin mst[i] <= 3; ment[i] <= cyc; end
          else if (cyc - ment[i] == T) begin mst[i] <= 2; ment[i] <= cyc; end
        end else if (mst[i] == 2) begin
          if (!EVState || r[i] || (AUTO && cyc - ment[i] == H)) begin mst[i] <= 3; ment[i] <= cyc; end
        end else if (mst[i] == 3 && cyc - ment[i] == T) mst[i] <= 0;
      end
      mden  <= d;
      mprev <= SwitchFlip;
      cyc   <= cyc + 1;
    end
  end

  always @(negedge Clock) begin
    automatic logic [NP-1:0] eo = '0;
    automatic logic [NP-1:0] em = '0;
    for (int i = 0; i < NP; i++) begin
      eo[i] = mst[i] == 2;
      em[i] = mst[i] == 1 || mst[i] == 3;
    end
    checks++;
    if ({OpenClose, Moving, Busy, Denied} !== {eo, em, |(eo | em), mden}) begin
      errors++;
      $display("FAIL model t=%0t OpenClose=%b/%b Moving=%b/%b Busy=%b/%b Denied=%b/%b (got/expected)",
               $time, OpenClose, eo, Moving, em, Busy, |(eo | em), Denied, mden);
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b", n, a, e);
    end
  endtask

  task automatic pulse(input logic [NP-1:0] m);
    SwitchFlip = m;
    step();
    SwitchFlip = '0;
  endtask

  task automatic travel_rest();
    repeat (T) step();
  endtask

  initial begin
    #1 Reset = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {OpenClose, Moving, Busy, Denied}, 8'b0);
    Reset = 1'b1;
    repeat (5) begin
      step();
      chk("held_switch_idle", {OpenClose, Moving, Busy, Denied}, 8'b0);
    end
    SwitchFlip = '0;
    EVState = 1'b1;
    step();
    pulse(2'b01);
    chk("open_moving", Moving, 8'b01);
    repeat (T - 1) begin
      step();
      chk("open_moving_hold", {OpenClose, Moving}, 8'b0001);
    end
    step();
    chk("opened", {OpenClose, Moving}, 8'b0100);
    pulse(2'b01);
    chk("close_moving", {OpenClose, Moving}, 8'b0001);
    travel_rest();
    chk("closed_idle", {OpenClose, Busy}, 8'b000);
    pulse(2'b11);
    chk("arb_winner", Moving, 8'b01);
    chk("arb_denied", Denied, 8'b10);
    step();
    chk("deny_one_cycle", Denied, 8'b00);
    repeat (T - 1) step();
    chk("arb_opened", OpenClose, 8'b01);
    pulse(2'b10);
    chk("interlock_denied", {OpenClose, Denied}, 8'b0110);
    step();
    chk("interlock_stays", {OpenClose, Moving, Denied}, 8'b010000);
    pulse(2'b01);
    travel_rest();
    chk("closed_again", Busy, 8'b0);
    EVState = 1'b0;
    pulse(2'b10);
    chk("ev_denied", {Moving, Denied}, 8'b0010);
    step();
    EVState = 1'b1;
    pulse(2'b01);
    travel_rest();
    chk("reopened", OpenClose, 8'b01);
    EVState = 1'b0;
    step();
    chk("force_close", {OpenClose, Moving}, 8'b0001);
    travel_rest();
    chk("force_closed", Busy, 8'b0);
    EVState = 1'b1;
    pulse(2'b01);
    step();
    chk("midtravel", Moving, 8'b01);
    Reset = 1'b0;
    #1;
    chk("async_reset", {OpenClose, Moving, Busy, Denied}, 8'b0);
    step();
    Reset = 1'b1;
    step();
    pulse(2'b01);
    travel_rest();
    chk("hold_open0", OpenClose, 8'b01);
`ifdef AUTO_CLOSE_EN
    repeat (H - 1) begin
      step();
      chk("hold_open", OpenClose, 8'b01);
    end
    step();
    chk("auto_close", {OpenClose, Moving}, 8'b0001);
    repeat (T - 1) step();
    step();
    chk("auto_closed", Busy, 8'b0);
`else
    repeat (H + 5) step();
    chk("stays_open", OpenClose, 8'b01);
    pulse(2'b01);
    travel_rest();
    chk("manual_closed", Busy, 8'b0);
`endif
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) SwitchFlip = SwitchFlip ^ NP'(1 << $urandom_range(0, NP - 1));
      if (EVState) EVState = $urandom_range(0, 39) != 0;
      else EVState = $urandom_range(0, 3) == 0;
      Reset = $urandom_range(0, 299) != 0;
      step();
    end
    Reset = 1'b1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oc_port_array.md
Name: oc_port_array

Overview:
- Parametrised successor to the single open/close port controller.
- Manages NUM_PORTS chamber ports, each with its own toggle switch and a timed travel phase.
- Enforces an interlock: at most one port is non-closed at any time. Opening is gated by EVState, and a port is force-closed if EVState drops.
- Sits between the user switches and the port actuators/indicators of the chamber controller.

Parameters:
- NUM_PORTS, 2, number of independent ports (>=1).
- TRAVEL_CYCLES, 4, clock cycles spent in OPENING or CLOSING (>=1, <=2**TRAVEL_W-1).
- TRAVEL_W, 8, width of the per-port travel counter.
- HOLD_CYCLES, 16, cycles a port stays OPEN before auto-close (used only with AUTO_CLOSE_EN).

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- SwitchFlip  in  NUM_PORTS  per-port toggle request; each rising edge is one request.
- EVState  in  1  1 = chamber equalised, ports may open; 0 = opening forbidden.
- OpenClose  out  NUM_PORTS  1 = port fully OPEN.
- Moving  out  NUM_PORTS  1 = port in OPENING or CLOSING.
- Busy  out  1  OR of all ports not CLOSED.
- Denied  out  NUM_PORTS  one-cycle pulse when an open request is rejected.

Behaviour:
- Reset (Reset=0, async):
  - all ports CLOSED; counters 0; OpenClose=0, Moving=0, Busy=0, Denied=0.
  - switch history register set to all ones, so a switch held high through reset must be released and re-pressed to request.
- Edge detect:
  - sw_q[i] registers SwitchFlip[i] each cycle.
  - req[i] = SwitchFlip[i] & ~sw_q[i] (combinational), acted on at the same rising edge.
- Per-port FSM, states CLOSED, OPENING, OPEN, CLOSING:
  - CLOSED + req: if EVState=1 and every other port is CLOSED and this port wins arbitration -> OPENING, cnt<=TRAVEL_CYCLES-1. Otherwise stay CLOSED and pulse Denied[i] for one cycle.
  - OPENING: cnt decrements each edge; at cnt==0 -> OPEN. OPENING lasts exactly TRAVEL_CYCLES cycles.
  - OPEN + req -> CLOSING, cnt<=TRAVEL_CYCLES-1.
  - CLOSING: decrements; at cnt==0 -> CLOSED. Lasts exactly TRAVEL_CYCLES cycles.
  - req during OPENING or CLOSING: ignored, no Denied.
- Safety: EVState=0 sampled while a port is OPENING or OPEN forces -> CLOSING, cnt<=TRAVEL_CYCLES-1, the same edge. This overrides a same-cycle req. The counter does not resume from elapsed time.
- Arbitration: simultaneous CLOSED-port requests on one edge -> lowest index wins. All other requesters get Denied.
- Interlock: a port in CLOSING still blocks others until it reaches CLOSED. A request arriving on the same edge that port becomes CLOSED is denied, because blocking uses the registered state.
- Outputs are decoded from registered state (Moore); Denied is registered.
  - OpenClose[i] = (state==OPEN); Moving[i] = OPENING|CLOSING; Busy = any state != CLOSED.
- Reset asserted mid-travel: immediate return to reset values, no completion of travel.
- Counter never wraps: loads only TRAVEL_CYCLES-1 and stops at 0.

Optional Feature:
- AUTO_CLOSE_EN defined:
  - per-port hold counter loads HOLD_CYCLES-1 on entry to OPEN and decrements each OPEN cycle.
  - at 0 the port goes -> CLOSING as if requested; a manual req before expiry closes immediately.
  - HOLD_CYCLES=1 means CLOSING starts after one OPEN cycle.
- AUTO_CLOSE_EN undefined: no hold counter logic; OPEN persists until req or EVState=0. HOLD_CYCLES is ignored.

Test Plan (NUM_PORTS=2, TRAVEL_CYCLES=4):
1. Reset=0 with SwitchFlip=2'b11, release Reset, hold switches high 5 cycles -> OpenClose=00, Moving=00, Busy=0, Denied=00 throughout.
2. EVState=1, rising edge on SwitchFlip[0] -> Moving=01 for 4 cycles, then OpenClose=01. Second edge -> Moving=01 4 cycles, then OpenClose=00, Busy=0.
3. Both switches rise on the same edge with EVState=1 -> port 0 OPENING, Denied=10 pulse for one cycle. Edge on port 1 while port 0 OPEN -> Denied=10 again, port 1 stays CLOSED.
4. EVState=0, edge on SwitchFlip[1] -> Denied=10 pulse, no movement.
5. Port 0 OPEN, drop EVState to 0 -> next edge Moving=01, CLOSED after 4 cycles. Then assert Reset=0 midway through a new OPENING -> outputs 0 immediately.
6. With AUTO_CLOSE_EN, HOLD_CYCLES=3: open port 0, no further req -> OpenClose=01 for exactly 3 cycles, then CLOSING 4 cycles, then CLOSED.
